// File: rtl/video_mode_pattern_gen.sv
// Video timing and test-pattern source.
// Timing and pattern are runtime-configurable through a valid/ready shadow slot.
// A new configuration goes live only at the end of a frame, so no frame is ever torn.
// Outputs trail the h/v counters by two register stages.
module video_mode_pattern_gen #(
  parameter int unsigned         X_BITS    = 12,
  parameter int unsigned         Y_BITS    = 12,
  parameter int unsigned         B         = 8,
  parameter int unsigned         FRAC_BITS = 12,
  parameter logic [4*X_BITS-1:0] DEF_H     = {12'd1650, 12'd110, 12'd40, 12'd220},
  parameter logic [4*Y_BITS-1:0] DEF_V     = {12'd750, 12'd5, 12'd5, 12'd20}
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [4*X_BITS-1:0]    cfg_h_timing,
  input  logic [4*Y_BITS-1:0]    cfg_v_timing,
  input  logic [2:0]             cfg_pattern,
  input  logic [3*B-1:0]         cfg_color,
  input  logic [FRAC_BITS+B-1:0] cfg_ramp_step,
  output logic                   cfg_err,
  output logic                   hs_n,
  output logic                   vs_n,
  output logic                   de,
  output logic [3*B-1:0]         rgb,
  output logic [X_BITS-1:0]      x_out,
  output logic [Y_BITS-1:0]      y_out,
  output logic                   frame_start
);

  localparam int unsigned RW = FRAC_BITS + B;
  localparam int unsigned CW = 3 * B;
  localparam int unsigned XS = X_BITS + 2;
  localparam int unsigned YS = Y_BITS + 2;

  // Live and shadow configuration.
  logic [4*X_BITS-1:0] h_live_q, sh_h_q;
  logic [4*Y_BITS-1:0] v_live_q, sh_v_q;
  logic [2:0]          pat_q, sh_pat_q;
  logic [CW-1:0]       color_q, sh_color_q;
  logic [RW-1:0]       step_q, sh_step_q;
  logic                pending_q, pending_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic                capture, apply, cfg_ok;

  // Counters.
  logic [X_BITS-1:0] h_cnt_q;
  logic [Y_BITS-1:0] v_cnt_q;
  logic              h_last, v_last;

  // Stage 1.
  logic              de1_q, hs1_q, vs1_q, fs1_q, edge1_q;
  logic [X_BITS-1:0] x1_q;
  logic [Y_BITS-1:0] y1_q;
  logic [RW-1:0]     acc_q;

  // Stage 2.
  logic              de_q, hs_n_q, vs_n_q, fs_q;
  logic [X_BITS-1:0] x_q;
  logic [Y_BITS-1:0] y_q;
  logic [CW-1:0]     rgb_q, rgb_d;

  // Derived timing, computed from the live fields.
  logic [X_BITS-1:0] h_tot, h_fp, h_sync, h_bp, h_act, hs_beg, hs_end;
  logic [Y_BITS-1:0] v_tot, v_fp, v_sync, v_bp, v_act, vs_beg, vs_end;
  assign h_tot  = h_live_q[4*X_BITS-1 -: X_BITS];
  assign h_fp   = h_live_q[3*X_BITS-1 -: X_BITS];
  assign h_sync = h_live_q[2*X_BITS-1 -: X_BITS];
  assign h_bp   = h_live_q[X_BITS-1:0];
  assign h_act  = h_tot - (h_fp + h_sync + h_bp);
  assign hs_beg = h_act + h_fp;
  assign hs_end = hs_beg + h_sync;
  assign v_tot  = v_live_q[4*Y_BITS-1 -: Y_BITS];
  assign v_fp   = v_live_q[3*Y_BITS-1 -: Y_BITS];
  assign v_sync = v_live_q[2*Y_BITS-1 -: Y_BITS];
  assign v_bp   = v_live_q[Y_BITS-1:0];
  assign v_act  = v_tot - (v_fp + v_sync + v_bp);
  assign vs_beg = v_act + v_fp;
  assign vs_end = vs_beg + v_sync;

  // Offered timing must leave a non-empty active region and a non-zero sync on both axes.
  logic [XS-1:0] cfg_h_sum;
  logic [YS-1:0] cfg_v_sum;
  assign cfg_h_sum = XS'(cfg_h_timing[3*X_BITS-1 -: X_BITS]) +
                     XS'(cfg_h_timing[2*X_BITS-1 -: X_BITS]) + XS'(cfg_h_timing[X_BITS-1:0]);
  assign cfg_v_sum = YS'(cfg_v_timing[3*Y_BITS-1 -: Y_BITS]) +
                     YS'(cfg_v_timing[2*Y_BITS-1 -: Y_BITS]) + YS'(cfg_v_timing[Y_BITS-1:0]);
  assign cfg_ok = (XS'(cfg_h_timing[4*X_BITS-1 -: X_BITS]) > cfg_h_sum) &&
                  (cfg_h_timing[2*X_BITS-1 -: X_BITS] != '0) &&
                  (YS'(cfg_v_timing[4*Y_BITS-1 -: Y_BITS]) > cfg_v_sum) &&
                  (cfg_v_timing[2*Y_BITS-1 -: Y_BITS] != '0);

  assign h_last = (h_cnt_q == h_tot - X_BITS'(1));
  assign v_last = (v_cnt_q == v_tot - Y_BITS'(1));
  assign apply  = pending_q && h_last && v_last;

  // Handshake control: capture a valid offer, flag a bad one, release the slot at apply.
  always_comb begin
    pending_d = pending_q;
    ready_d   = ready_q;
    err_d     = err_q;
    capture   = 1'b0;
    if (apply) begin
      pending_d = 1'b0;
      ready_d   = 1'b1;
    end
    if (cfg_valid && ready_q) begin
      if (cfg_ok) begin
        capture   = 1'b1;
        pending_d = 1'b1;
        ready_d   = 1'b0;
        err_d     = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Configuration registers: shadow capture and frame-end copy to live.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      h_live_q   <= DEF_H;
      v_live_q   <= DEF_V;
      pat_q      <= 3'd5;
      color_q    <= '0;
      step_q     <= '0;
      sh_h_q     <= '0;
      sh_v_q     <= '0;
      sh_pat_q   <= '0;
      sh_color_q <= '0;
      sh_step_q  <= '0;
      pending_q  <= 1'b0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      if (capture) begin
        sh_h_q     <= cfg_h_timing;
        sh_v_q     <= cfg_v_timing;
        sh_pat_q   <= cfg_pattern;
        sh_color_q <= cfg_color;
        sh_step_q  <= cfg_ramp_step;
      end
      if (apply) begin
        h_live_q <= sh_h_q;
        v_live_q <= sh_v_q;
        pat_q    <= sh_pat_q;
        color_q  <= sh_color_q;
        step_q   <= sh_step_q;
      end
    end
  end

  // Raster counters; both wrap together at frame end, where new timing takes over.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else if (h_last) begin
      h_cnt_q <= '0;
      v_cnt_q <= v_last ? '0 : v_cnt_q + Y_BITS'(1);
    end else begin
      h_cnt_q <= h_cnt_q + X_BITS'(1);
    end
  end

  // Stage 1: decode sync/de/border, latch coordinates, advance the ramp accumulator.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      de1_q   <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      fs1_q   <= 1'b0;
      edge1_q <= 1'b0;
      x1_q    <= '0;
      y1_q    <= '0;
      acc_q   <= '0;
    end else begin
      de1_q   <= (h_cnt_q < h_act) && (v_cnt_q < v_act);
      hs1_q   <= (h_cnt_q >= hs_beg) && (h_cnt_q < hs_end);
      vs1_q   <= (v_cnt_q >= vs_beg) && (v_cnt_q < vs_end);
      fs1_q   <= (h_cnt_q == '0) && (v_cnt_q == '0);
      edge1_q <= (h_cnt_q == '0) || (h_cnt_q == h_act - X_BITS'(1)) ||
                 (v_cnt_q == '0) || (v_cnt_q == v_act - Y_BITS'(1));
      x1_q    <= h_cnt_q;
      y1_q    <= v_cnt_q;
      acc_q   <= (h_cnt_q == '0) ? '0 : acc_q + step_q;
    end
  end

  // Pattern colour for the stage-1 pixel; black outside the active area.
  always_comb begin
    rgb_d = '0;
    if (de1_q) begin
      case (pat_q)
        3'd0:    rgb_d = color_q;
        3'd1:    rgb_d = edge1_q ? '1 : '0;
        3'd2:    rgb_d = x1_q[0] ? '1 : '0;
        3'd3:    rgb_d = y1_q[0] ? '1 : '0;
        3'd4:    rgb_d = {3{acc_q[RW-1 -: B]}};
        3'd5:    rgb_d = {3{x1_q[B-1:0] ^ y1_q[B-1:0]}};
        default: rgb_d = '0;
      endcase
    end
  end

  // Stage 2: output registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      de_q   <= 1'b0;
      hs_n_q <= 1'b1;
      vs_n_q <= 1'b1;
      fs_q   <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      rgb_q  <= '0;
    end else begin
      de_q   <= de1_q;
      hs_n_q <= ~hs1_q;
      vs_n_q <= ~vs1_q;
      fs_q   <= fs1_q;
      x_q    <= x1_q;
      y_q    <= y1_q;
      rgb_q  <= rgb_d;
    end
  end

  assign cfg_ready   = ready_q;
  assign cfg_err     = err_q;
  assign hs_n        = hs_n_q;
  assign vs_n        = vs_n_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign x_out       = x_q;
  assign y_out       = y_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_video_mode_pattern_gen.sv
// Directed bench for video_mode_pattern_gen with a small 16x8 default raster.
module tb_video_mode_pattern_gen;

  localparam int unsigned XB = 12;
  localparam int unsigned YB = 12;

  logic          clk_in = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [47:0]   cfg_h_timing = '0;
  logic [47:0]   cfg_v_timing = '0;
  logic [2:0]    cfg_pattern = '0;
  logic [23:0]   cfg_color = '0;
  logic [19:0]   cfg_ramp_step = '0;
  logic          cfg_err;
  logic          hs_n, vs_n, de, frame_start;
  logic [23:0]   rgb;
  logic [11:0]   x_out, y_out;

  int checks = 0;
  int errors = 0;

  video_mode_pattern_gen #(
    .X_BITS(12), .Y_BITS(12), .B(8), .FRAC_BITS(12),
    .DEF_H({12'd16, 12'd2, 12'd2, 12'd2}),
    .DEF_V({12'd8, 12'd1, 12'd1, 12'd1})
  ) dut (
    .clk_in(clk_in), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h_timing(cfg_h_timing), .cfg_v_timing(cfg_v_timing), .cfg_pattern(cfg_pattern),
    .cfg_color(cfg_color), .cfg_ramp_step(cfg_ramp_step), .cfg_err(cfg_err),
    .hs_n(hs_n), .vs_n(vs_n), .de(de), .rgb(rgb), .x_out(x_out), .y_out(y_out),
    .frame_start(frame_start)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic offer(input int ht, input int hf, input int hs, input int hb,
                       input int vt, input int vf, input int vs, input int vb,
                       input logic [2:0] pat, input logic [23:0] col, input logic [19:0] step);
    cfg_h_timing  = {XB'(ht), XB'(hf), XB'(hs), XB'(hb)};
    cfg_v_timing  = {YB'(vt), YB'(vf), YB'(vs), YB'(vb)};
    cfg_pattern   = pat;
    cfg_color     = col;
    cfg_ramp_step = step;
    cfg_valid     = 1'b1;
    tick();
    cfg_valid     = 1'b0;
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // From a de rising sample: count active samples and samples until the next de rise.
  task automatic measure_line(output int act, output int per);
    act = 0;
    per = 0;
    while (de === 1'b1 && act < 100) begin
      act++;
      per++;
      tick();
    end
    while (de !== 1'b1 && per < 200) begin
      per++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (hs_n !== 1'b1 || vs_n !== 1'b1 || de !== 1'b0 || rgb !== 24'h0 ||
        x_out !== 12'h0 || y_out !== 12'h0 || frame_start !== 1'b0)
      begin errors++; $display("FAIL reset_outputs got hs_n=%b vs_n=%b de=%b rgb=%h x=%0d y=%0d fs=%b required 1 1 0 0 0 0 0",
        hs_n, vs_n, de, rgb, x_out, y_out, frame_start); end
    checks++;
    if (cfg_ready !== 1'b1 || cfg_err !== 1'b0)
      begin errors++; $display("FAIL reset_cfg got ready=%b err=%b required 1 0", cfg_ready, cfg_err); end
    reset = 1'b0;
    tick();
    checks++;
    if (de !== 1'b0) begin errors++; $display("FAIL first_de_early got %b required 0", de); end
    tick();
    checks++;
    if (de !== 1'b1 || frame_start !== 1'b1 || x_out !== 12'h0 || y_out !== 12'h0 || rgb !== 24'h0)
      begin errors++; $display("FAIL first_de got de=%b fs=%b x=%0d y=%0d rgb=%h required 1 1 0 0 0",
        de, frame_start, x_out, y_out, rgb); end
  endtask

  // One full 16x8 frame of the xor pattern starting at the current frame_start sample.
  task automatic test_timing();
    int de_cnt [8];
    int hs_first, hs_low0, h, v;
    logic exp_de, exp_hs_n, exp_vs_n;
    logic [23:0] exp_rgb;
    hs_first = -1;
    hs_low0  = 0;
    for (int k = 0; k < 8; k++) de_cnt[k] = 0;
    for (int i = 0; i < 128; i++) begin
      h = i % 16;
      v = i / 16;
      exp_de   = (h < 10) && (v < 5);
      exp_hs_n = !((h >= 12) && (h < 14));
      exp_vs_n = (v != 6);
      exp_rgb  = exp_de ? {3{8'(h ^ v)}} : 24'h0;
      checks++;
      if (de !== exp_de) begin errors++; $display("FAIL timing_de n=%0d got %b required %b", i, de, exp_de); end
      checks++;
      if (hs_n !== exp_hs_n) begin errors++; $display("FAIL timing_hs n=%0d got %b required %b", i, hs_n, exp_hs_n); end
      checks++;
      if (vs_n !== exp_vs_n) begin errors++; $display("FAIL timing_vs n=%0d got %b required %b", i, vs_n, exp_vs_n); end
      checks++;
      if (frame_start !== (i == 0)) begin errors++; $display("FAIL timing_fs n=%0d got %b", i, frame_start); end
      checks++;
      if (rgb !== exp_rgb) begin errors++; $display("FAIL xor_rgb n=%0d got %h required %h", i, rgb, exp_rgb); end
      if (exp_de) begin
        checks++;
        if (x_out !== 12'(h) || y_out !== 12'(v))
          begin errors++; $display("FAIL xy n=%0d got %0d,%0d required %0d,%0d", i, x_out, y_out, h, v); end
      end
      if (de === 1'b1) de_cnt[v]++;
      if (v == 0 && hs_n === 1'b0) begin
        if (hs_first < 0) hs_first = i;
        hs_low0++;
      end
      tick();
    end
    checks++;
    if (frame_start !== 1'b1) begin errors++; $display("FAIL frame_period got fs=%b at 128 required 1", frame_start); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (de_cnt[k] != ((k < 5) ? 10 : 0))
        begin errors++; $display("FAIL de_per_line line=%0d got %0d required %0d", k, de_cnt[k], (k < 5) ? 10 : 0); end
    end
    checks++;
    if (hs_first != 12 || hs_low0 != 2)
      begin errors++; $display("FAIL hs_position got start=%0d len=%0d required 12 2", hs_first, hs_low0); end
  endtask

  task automatic test_cfg_apply();
    int act, per, guard;
    logic r1, r2, r3;
    bit found;
    for (int i = 0; i < 20; i++) tick();
    offer(20, 2, 2, 2, 8, 1, 1, 1, 3'd5, 24'h0, 20'h0);
    checks++;
    if (cfg_ready !== 1'b0 || cfg_err !== 1'b0)
      begin errors++; $display("FAIL apply_ready_drop got ready=%b err=%b required 0 0", cfg_ready, cfg_err); end
    guard = 0;
    while (de === 1'b1 && guard < 50) begin tick(); guard++; end
    while (de !== 1'b1 && guard < 100) begin tick(); guard++; end
    measure_line(act, per);
    checks++;
    if (act != 10 || per != 16)
      begin errors++; $display("FAIL old_line got act=%0d period=%0d required 10 16", act, per); end
    r1 = cfg_ready;
    r2 = cfg_ready;
    r3 = cfg_ready;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (frame_start === 1'b1) begin found = 1'b1; break; end
      r3 = r2;
      r2 = r1;
      r1 = cfg_ready;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL apply_wait_fs got timeout required frame_start"); end
    checks++;
    if (cfg_ready !== 1'b1 || r3 !== 1'b0)
      begin errors++; $display("FAIL apply_ready got ready=%b earlier=%b required 1 0", cfg_ready, r3); end
    measure_line(act, per);
    checks++;
    if (act != 14 || per != 20)
      begin errors++; $display("FAIL new_line got act=%0d period=%0d required 14 20", act, per); end
  endtask

  task automatic test_cfg_err();
    int act, per, cnt;
    bit ok;
    offer(10, 4, 4, 4, 8, 1, 1, 1, 3'd5, 24'h0, 20'h0);
    checks++;
    if (cfg_err !== 1'b1 || cfg_ready !== 1'b1)
      begin errors++; $display("FAIL bad_h got err=%b ready=%b required 1 1", cfg_err, cfg_ready); end
    wait_fs(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL err_wait_fs got timeout required frame_start"); end
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      cnt++;
      if (frame_start === 1'b1) break;
    end
    checks++;
    if (cnt != 160) begin errors++; $display("FAIL err_frame_period got %0d required 160", cnt); end
    measure_line(act, per);
    checks++;
    if (act != 14 || per != 20)
      begin errors++; $display("FAIL err_line got act=%0d period=%0d required 14 20", act, per); end
    offer(16, 2, 2, 2, 8, 1, 1, 1, 3'd4, 24'h0, 20'h01000);
    checks++;
    if (cfg_err !== 1'b0 || cfg_ready !== 1'b0)
      begin errors++; $display("FAIL err_clear got err=%b ready=%b required 0 0", cfg_err, cfg_ready); end
  endtask

  task automatic test_ramp();
    int h, v;
    bit ok;
    logic exp_de;
    logic [23:0] exp_rgb;
    wait_fs(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ramp_wait_fs got timeout required frame_start"); end
    for (int i = 0; i < 128; i++) begin
      h = i % 16;
      v = i / 16;
      exp_de  = (h < 10) && (v < 5);
      exp_rgb = exp_de ? {3{8'(h)}} : 24'h0;
      checks++;
      if (de !== exp_de || rgb !== exp_rgb)
        begin errors++; $display("FAIL ramp n=%0d got de=%b rgb=%h required %b %h", i, de, rgb, exp_de, exp_rgb); end
      tick();
    end
  endtask

  task automatic test_border();
    int h, v;
    bit ok;
    logic exp_de;
    logic [23:0] exp_rgb;
    offer(16, 2, 2, 2, 8, 1, 0, 1, 3'd1, 24'h0, 20'h0);
    checks++;
    if (cfg_err !== 1'b1 || cfg_ready !== 1'b1)
      begin errors++; $display("FAIL bad_vsync got err=%b ready=%b required 1 1", cfg_err, cfg_ready); end
    offer(16, 2, 2, 2, 8, 1, 1, 1, 3'd1, 24'h0, 20'h0);
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL border_err_clear got %b required 0", cfg_err); end
    wait_fs(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL border_wait_fs got timeout required frame_start"); end
    for (int i = 0; i < 128; i++) begin
      h = i % 16;
      v = i / 16;
      exp_de  = (h < 10) && (v < 5);
      exp_rgb = (exp_de && (h == 0 || h == 9 || v == 0 || v == 4)) ? 24'hFFFFFF : 24'h0;
      checks++;
      if (rgb !== exp_rgb)
        begin errors++; $display("FAIL border n=%0d got %h required %h", i, rgb, exp_rgb); end
      tick();
    end
  endtask

  task automatic test_patterns();
    logic [2:0] pats [4];
    int h, v;
    bit ok;
    logic exp_de;
    logic [23:0] exp_rgb;
    pats = '{3'd0, 3'd2, 3'd3, 3'd7};
    for (int p = 0; p < 4; p++) begin
      offer(16, 2, 2, 2, 8, 1, 1, 1, pats[p], 24'h123456, 20'h0);
      wait_fs(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL pattern_wait_fs pat=%0d got timeout required frame_start", pats[p]); end
      for (int i = 0; i < 128; i++) begin
        h = i % 16;
        v = i / 16;
        exp_de = (h < 10) && (v < 5);
        case (pats[p])
          3'd0:    exp_rgb = 24'h123456;
          3'd2:    exp_rgb = (h % 2 == 1) ? 24'hFFFFFF : 24'h0;
          3'd3:    exp_rgb = (v % 2 == 1) ? 24'hFFFFFF : 24'h0;
          default: exp_rgb = 24'h0;
        endcase
        if (!exp_de) exp_rgb = 24'h0;
        checks++;
        if (rgb !== exp_rgb)
          begin errors++; $display("FAIL pattern pat=%0d n=%0d got %h required %h", pats[p], i, rgb, exp_rgb); end
        tick();
      end
    end
  endtask

  task automatic test_reset_midline();
    int act, per, cnt;
    offer(20, 2, 2, 2, 8, 1, 1, 1, 3'd5, 24'h0, 20'h0);
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_pending got ready=%b required 0", cfg_ready); end
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (hs_n !== 1'b1 || vs_n !== 1'b1 || de !== 1'b0 || rgb !== 24'h0 || x_out !== 12'h0 ||
        y_out !== 12'h0 || frame_start !== 1'b0 || cfg_ready !== 1'b1 || cfg_err !== 1'b0)
      begin errors++; $display("FAIL mid_reset got hs_n=%b vs_n=%b de=%b rgb=%h x=%0d y=%0d fs=%b rdy=%b err=%b required 1 1 0 0 0 0 0 1 0",
        hs_n, vs_n, de, rgb, x_out, y_out, frame_start, cfg_ready, cfg_err); end
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (de !== 1'b1 || frame_start !== 1'b1)
      begin errors++; $display("FAIL mid_restart got de=%b fs=%b required 1 1", de, frame_start); end
    measure_line(act, per);
    checks++;
    if (act != 10 || per != 16)
      begin errors++; $display("FAIL mid_def_line got act=%0d period=%0d required 10 16", act, per); end
    cnt = per;
    for (int i = 0; i < 400; i++) begin
      tick();
      cnt++;
      if (frame_start === 1'b1) break;
    end
    checks++;
    if (cnt != 128) begin errors++; $display("FAIL mid_frame_period got %0d required 128", cnt); end
    measure_line(act, per);
    checks++;
    if (act != 10 || per != 16 || cfg_ready !== 1'b1)
      begin errors++; $display("FAIL mid_dropped got act=%0d period=%0d ready=%b required 10 16 1", act, per, cfg_ready); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_cfg_apply();
    test_cfg_err();
    test_ramp();
    test_border();
    test_patterns();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
